ps2_key_injector: RTL and testbench

- Synthesizable PS/2 keyboard-device emulator; replaces bench-level PS/2 send and key-press tasks with a parametrised hardware block.
- Accepts scancodes from a queue. For each code it transmits the make sequence, holds the key for a set number of frames, then transmits the break sequence.
- Sits between a stimulus source (bench, debugger, or scripted ROM) and the BBC_MICRO PS2_CLK/PS2_DATA inputs.
- Adds over the task-based version: extended (E0) codes, a FIFO of queued keys, correct odd parity, and configurable timing.

---
 rtl/ps2_inject_pkg.sv | 34 +++
 rtl/ps2_byte_tx.sv | 90 +++++++++
 rtl/ps2_key_injector.sv | 185 ++++++++++++++++++
 tb/tb_ps2_key_injector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_inject_pkg.sv
// ps2_inject_pkg
// Shared types and constants for the PS/2 key injector:
//   seq_state_t  - key sequencer states
//   PS2_EXT      - extended-code prefix byte
//   PS2_BREAK    - break (release) prefix byte
//   PS2_FRAME_BITS - bits per PS/2 device-to-host frame
//   odd_parity() / ps2_frame() - frame construction helpers
package ps2_inject_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAKE_E0,
        S_MAKE_CODE,
        S_HOLD,
        S_BRK_E0,
        S_BRK_F0,
        S_BRK_CODE,
        S_GAP
    } seq_state_t;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Bit k of the result is the k-th bit on the wire: start, D0..D7, parity, stop.
    function automatic logic [10:0] ps2_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_byte_tx.sv
// ps2_byte_tx
// Free-running PS/2 device clock plus an 11-bit frame shifter.
// Ports:
//   clk      - system clock
//   rst_b    - synchronous active-low reset
//   start    - request to send data (accepted when ready)
//   data     - byte to send
//   ready    - idle, or finishing a frame this cycle (back-to-back accept)
//   done     - one-cycle pulse on the PS2_CLK rise after the stop bit
//   ps2_clk  - emulated device clock, period 2*CLK_DIV
//   ps2_data - emulated device data, idles high
module ps2_byte_tx
    import ps2_inject_pkg::*;
#(
    parameter int CLK_DIV    = 256,
    parameter int DATA_DELAY = 150
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div;
    logic [DW-1:0] tmr;
    logic          armed;
    logic          busy;
    logic [3:0]    bit_idx;
    logic [10:0]   frame;
    logic          wrap;
    logic          rise;
    logic          accept;

    assign wrap   = (div == DW'(CLK_DIV - 1));
    // Strobe is high in the cycle whose closing edge drives ps2_clk 0->1.
    assign rise   = wrap && !ps2_clk;
    assign done   = busy && rise && (bit_idx == 4'(PS2_FRAME_BITS));
    assign ready  = !busy || done;
    assign accept = start && ready;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            div      <= '0;
            ps2_clk  <= 1'b0;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
            armed    <= 1'b0;
            tmr      <= '0;
            bit_idx  <= '0;
            frame    <= '1;
        end else begin
            if (wrap) begin
                div     <= '0;
                ps2_clk <= ~ps2_clk;
            end else begin
                div <= div + 1'b1;
            end

            if (accept) begin
                frame   <= ps2_frame(data);
                busy    <= 1'b1;
                bit_idx <= '0;
            end else if (done) begin
                busy <= 1'b0;
            end

            // Each PS2_CLK rise arms the delay timer for the next bit; an accept
            // landing on a rise (including the done cycle) uses that same rise.
            if (rise && (accept || (busy && bit_idx < 4'(PS2_FRAME_BITS)))) begin
                armed <= 1'b1;
                tmr   <= DW'(DATA_DELAY - 1);
            end else if (armed) begin
                if (tmr == '0) begin
                    armed    <= 1'b0;
                    ps2_data <= frame[bit_idx];
                    bit_idx  <= bit_idx + 1'b1;
                end else begin
                    tmr <= tmr - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_injector.sv
// ps2_key_injector
// PS/2 keyboard emulator: queues keys and plays make / hold / break / gap.
//
// state       | meaning
// ------------+----------------------------------------------
// S_IDLE      | waiting for a queued key; pops it when present
// S_MAKE_E0   | sending E0 prefix of an extended make
// S_MAKE_CODE | sending the make scancode
// S_HOLD      | key held, counting HOLD_FRAMES VSYNC rises
// S_BRK_E0    | sending E0 prefix of an extended break
// S_BRK_F0    | sending F0 break prefix
// S_BRK_CODE  | sending the break scancode
// S_GAP       | counting GAP_FRAMES VSYNC rises before next key
//
// Ports:
//   CLK, nRESET            - system clock, synchronous active-low reset
//   KEY_VALID/CODE/EXT     - enqueue request and entry
//   KEY_READY              - queue not full
//   VSYNC                  - frame marker (CLK-synchronous)
//   PS2_CLK, PS2_DATA      - emulated device lines
//   BUSY                   - queue non-empty or a key in progress
//   OVERFLOW               - sticky: push attempted while full
module ps2_key_injector
    import ps2_inject_pkg::*;
#(
    parameter int CLK_DIV     = 256,
    parameter int DATA_DELAY  = 150,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_FRAMES = 4,
    parameter int GAP_FRAMES  = 2
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       KEY_VALID,
    input  logic [7:0] KEY_CODE,
    input  logic       KEY_EXT,
    output logic       KEY_READY,
    input  logic       VSYNC,
    output logic       PS2_CLK,
    output logic       PS2_DATA,
    output logic       BUSY,
    output logic       OVERFLOW
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int FMAX = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
    localparam int FW   = (FMAX > 0) ? $clog2(FMAX + 1) : 1;

    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [8:0]    head;

    logic          vsync_q;
    logic          vsync_rise;

    seq_state_t    state;
    seq_state_t    state_nx;
    logic [7:0]    cur_code;
    logic          cur_ext;
    logic [FW-1:0] frame_cnt;
    logic          sent;

    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          tx_done;

    assign KEY_READY = (count != CW'(FIFO_DEPTH));
    assign push      = KEY_VALID && KEY_READY;
    assign head      = fifo_mem[rd_ptr];
    assign BUSY      = (count != '0) || (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= {KEY_EXT, KEY_CODE};
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (KEY_VALID && !KEY_READY) OVERFLOW <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            vsync_q    <= 1'b0;
            vsync_rise <= 1'b0;
        end else begin
            vsync_q    <= VSYNC;
            vsync_rise <= VSYNC && !vsync_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (count != '0) state_nx = head[8] ? S_MAKE_E0 : S_MAKE_CODE;
            S_MAKE_E0:   if (tx_done) state_nx = S_MAKE_CODE;
            S_MAKE_CODE: if (tx_done) state_nx = S_HOLD;
            S_HOLD:      if (frame_cnt == FW'(HOLD_FRAMES)) state_nx = cur_ext ? S_BRK_E0 : S_BRK_F0;
            S_BRK_E0:    if (tx_done) state_nx = S_BRK_F0;
            S_BRK_F0:    if (tx_done) state_nx = S_BRK_CODE;
            S_BRK_CODE:  if (tx_done) state_nx = S_GAP;
            S_GAP:       if (frame_cnt == FW'(GAP_FRAMES)) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        pop      = (state == S_IDLE) && (count != '0);
        tx_start = 1'b0;
        tx_data  = cur_code;
        case (state)
            S_MAKE_E0, S_BRK_E0: begin
                tx_start = !sent;
                tx_data  = PS2_EXT;
            end
            S_BRK_F0: begin
                tx_start = !sent;
                tx_data  = PS2_BREAK;
            end
            S_MAKE_CODE, S_BRK_CODE: tx_start = !sent;
            default: ;
        endcase
    end

    // Per-state bookkeeping: current key, one-start-per-state flag, frame count.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            cur_code  <= '0;
            cur_ext   <= 1'b0;
            sent      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (pop) begin
                cur_code <= head[7:0];
                cur_ext  <= head[8];
            end
            if (state != state_nx) begin
                sent      <= 1'b0;
                frame_cnt <= '0;
            end else begin
                if (tx_start && tx_ready) sent <= 1'b1;
                if (vsync_rise && (state == S_HOLD || state == S_GAP))
                    frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    ps2_byte_tx #(
        .CLK_DIV    (CLK_DIV),
        .DATA_DELAY (DATA_DELAY)
    ) u_tx (
        .clk      (CLK),
        .rst_b    (nRESET),
        .start    (tx_start),
        .data     (tx_data),
        .ready    (tx_ready),
        .done     (tx_done),
        .ps2_clk  (PS2_CLK),
        .ps2_data (PS2_DATA)
    );

endmodule

// File: tb/tb_ps2_key_injector.sv
// tb_ps2_key_injector
// Self-checking bench: drives key bursts, decodes the PS/2 line on falling
// PS2_CLK edges and compares bytes, parity, stop bits, frame spacing and
// data timing against a key-level reference model.
module tb_ps2_key_injector;

    localparam int CLK_DIV     = 8;
    localparam int DATA_DELAY  = 3;
    localparam int FIFO_DEPTH  = 4;
    localparam int HOLD_FRAMES = 2;
    localparam int GAP_FRAMES  = 1;
    localparam int VS_PERIOD   = 600;
    localparam int IDLE_BUDGET = 30000;
    // From idle, one key pops to the sequencer right away, so one extra fits.
    localparam int BURST_CAP   = FIFO_DEPTH + 1;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       KEY_VALID = 1'b0;
    logic [7:0] KEY_CODE = '0;
    logic       KEY_EXT = 1'b0;
    logic       VSYNC = 1'b0;
    logic       KEY_READY, PS2_CLK, PS2_DATA, BUSY, OVERFLOW;

    ps2_key_injector #(
        .CLK_DIV     (CLK_DIV),
        .DATA_DELAY  (DATA_DELAY),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_FRAMES (HOLD_FRAMES),
        .GAP_FRAMES  (GAP_FRAMES)
    ) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .KEY_VALID (KEY_VALID),
        .KEY_CODE  (KEY_CODE),
        .KEY_EXT   (KEY_EXT),
        .KEY_READY (KEY_READY),
        .VSYNC     (VSYNC),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .BUSY      (BUSY),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int vs_cnt   = 0;
    int starts   = 0;
    logic ovf_model = 1'b0;
    logic [7:0] exp_q[$];
    int byte_vs[$];
    logic [8:0] burst_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a key expands to its make bytes then its break bytes.
    task automatic add_expected(input logic [8:0] key);
        if (key[8]) exp_q.push_back(8'hE0);
        exp_q.push_back(key[7:0]);
        if (key[8]) exp_q.push_back(8'hE0);
        exp_q.push_back(8'hF0);
        exp_q.push_back(key[7:0]);
    endtask

    initial begin
        forever begin
            repeat (VS_PERIOD - 1) @(negedge CLK);
            VSYNC = 1'b1;
            vs_cnt++;
            @(negedge CLK);
            VSYNC = 1'b0;
        end
    end

    // Line monitor: frame decode on PS2_CLK falls, data-change timing vs rises.
    initial begin
        logic p_clk, p_data, p_live;
        logic [9:0] sh;
        int since, st;
        p_clk = 1'b0; p_data = 1'b1; p_live = 1'b0; since = 100; st = 0; sh = '0;
        forever begin
            @(negedge CLK);
            if (!nRESET) begin
                st = 0; since = 100; p_live = 1'b0;
                p_clk = PS2_CLK; p_data = PS2_DATA;
            end else begin
                if (PS2_CLK && !p_clk) since = 0;
                else since++;
                if (p_live && PS2_DATA !== p_data) check("data_timing", since, DATA_DELAY);
                if (!PS2_CLK && p_clk) begin
                    if (st == 0) begin
                        if (PS2_DATA == 1'b0) begin st = 1; starts++; end
                    end else begin
                        sh[st-1] = PS2_DATA;
                        st++;
                        if (st == 11) begin
                            st = 0;
                            check("parity", ^sh[8:0], 1);
                            check("stop_bit", sh[9], 1);
                            if (exp_q.size() == 0) check("extra_byte", {24'd0, sh[7:0]}, 32'h100);
                            else check("byte", sh[7:0], exp_q.pop_front());
                            byte_vs.push_back(vs_cnt);
                        end
                    end
                end
                p_clk = PS2_CLK; p_data = PS2_DATA; p_live = 1'b1;
            end
        end
    end

    task automatic run_burst();
        int n;
        n = burst_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (i > 0) check("key_ready", KEY_READY, (i < BURST_CAP));
            KEY_VALID = 1'b1;
            {KEY_EXT, KEY_CODE} = burst_q[i];
            if (i < BURST_CAP) add_expected(burst_q[i]);
        end
        @(negedge CLK);
        check("key_ready_end", KEY_READY, (n < BURST_CAP));
        KEY_VALID = 1'b0;
        if (n > BURST_CAP) ovf_model = 1'b1;
        check("overflow", OVERFLOW, ovf_model);
        burst_q.delete();
    endtask

    task automatic wait_idle(output int vs_at);
        int k;
        k = 0;
        while (BUSY && k < IDLE_BUDGET) begin
            @(negedge CLK);
            k++;
        end
        check("idle_timeout", (k < IDLE_BUDGET), 1);
        vs_at = vs_cnt;
        repeat (40) @(negedge CLK);
        check("bytes_left", exp_q.size(), 0);
    endtask

    initial begin
        int base, vs_at, s0, nb;
        repeat (3) @(negedge CLK);
        check("rst_ps2_data", PS2_DATA, 1);
        check("rst_ps2_clk", PS2_CLK, 0);
        check("rst_busy", BUSY, 0);
        check("rst_key_ready", KEY_READY, 1);
        check("rst_overflow", OVERFLOW, 0);
        nRESET = 1'b1;
        repeat (20) @(negedge CLK);

        // Reset in the middle of a byte.
        burst_q.push_back({1'b0, 8'h3A});
        run_burst();
        repeat (80) @(negedge CLK);
        nRESET = 1'b0;
        @(negedge CLK);
        check("mid_rst_data", PS2_DATA, 1);
        check("mid_rst_clk", PS2_CLK, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_ready", KEY_READY, 1);
        repeat (2) @(negedge CLK);
        exp_q.delete();
        nRESET = 1'b1;
        @(negedge CLK);
        check("post_rst_data", PS2_DATA, 1);
        check("post_rst_clk", PS2_CLK, 0);
        s0 = starts;
        repeat (800) @(negedge CLK);
        check("post_rst_no_bits", starts - s0, 0);
        check("post_rst_busy", BUSY, 0);

        // Single plain key: hold and gap spacing in VSYNC rises.
        base = byte_vs.size();
        burst_q.push_back({1'b0, 8'h3A});
        run_burst();
        wait_idle(vs_at);
        check("single_nbytes", byte_vs.size() - base, 3);
        if (byte_vs.size() == base + 3) begin
            check("single_hold_rises", byte_vs[base+1] - byte_vs[base], HOLD_FRAMES);
            check("single_gap_rises", vs_at - byte_vs[base+2], GAP_FRAMES);
        end

        // Extended key.
        base = byte_vs.size();
        burst_q.push_back({1'b1, 8'h75});
        run_burst();
        wait_idle(vs_at);
        check("ext_nbytes", byte_vs.size() - base, 5);
        if (byte_vs.size() == base + 5)
            check("ext_hold_rises", byte_vs[base+2] - byte_vs[base+1], HOLD_FRAMES);

        // Five keys back to back.
        burst_q.push_back({1'b0, 8'h45});
        burst_q.push_back({1'b0, 8'h16});
        burst_q.push_back({1'b0, 8'h1E});
        burst_q.push_back({1'b0, 8'h26});
        burst_q.push_back({1'b0, 8'h25});
        run_burst();
        wait_idle(vs_at);

        // Random bursts within capacity.
        for (int r = 0; r < 2; r++) begin
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++)
                burst_q.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
            run_burst();
            wait_idle(vs_at);
        end
        check("ovf_still_clear", OVERFLOW, 0);

        // Overflow: six pushes from idle, the sixth is dropped.
        for (int i = 0; i < 6; i++)
            burst_q.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
        run_burst();
        wait_idle(vs_at);
        check("ovf_sticky", OVERFLOW, 1);
        check("final_ready", KEY_READY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
